// File: rtl/ram_write_scheduler.sv
// ram_write_scheduler: clears a multi-read-port RAM, then round-robin shares its single write port
module ram_write_scheduler #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_DEPTH = 1024,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ = 4,
  localparam int IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                                 Clk_CI,
  input  logic                                 Rst_RBI,
  input  logic                                 Flush_SI,
  input  logic [NUM_REQ-1:0]                   ReqValid_SI,
  output logic [NUM_REQ-1:0]                   ReqReady_SO,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   ReqAddr_DI,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   ReqData_DI,
  output logic                                 WrEn_SO,
  output logic [ADDR_WIDTH-1:0]                WrAddr_DO,
  output logic [DATA_WIDTH-1:0]                WrData_DO,
  output logic [IDX_WIDTH-1:0]                 GrantIdx_DO,
  output logic                                 Busy_SO,
  output logic                                 AddrErr_SO
);
  typedef enum logic {CLEAR, RUN} state_t;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DATA_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(DATA_DEPTH);
  state_t state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [IDX_WIDTH-1:0] ptr, gnt_idx;
  logic gnt_any, gnt;
  // pick the first valid requester at or after the pointer, wrapping around
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (ReqValid_SI[(int'(ptr) + k) % NUM_REQ]) begin
        gnt_any = 1'b1;
        gnt_idx = IDX_WIDTH'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end
  assign gnt = state == RUN && !Flush_SI && gnt_any;
  assign ReqReady_SO = gnt ? NUM_REQ'(1) << gnt_idx : '0;
  assign Busy_SO = state == CLEAR;
  // clear sweep, flush entry and registered write-port drive
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state       <= CLEAR;
      cnt         <= '0;
      ptr         <= '0;
      WrEn_SO     <= 1'b0;
      WrAddr_DO   <= '0;
      WrData_DO   <= '0;
      GrantIdx_DO <= '0;
      AddrErr_SO  <= 1'b0;
    end else begin
      WrEn_SO    <= 1'b0;
      AddrErr_SO <= 1'b0;
      if (state == CLEAR) begin
        WrEn_SO   <= 1'b1;
        WrAddr_DO <= cnt;
        WrData_DO <= '0;
        cnt       <= cnt + 1'b1;
        if (cnt == LAST) state <= RUN;
      end else if (Flush_SI) begin
        state <= CLEAR;
        cnt   <= '0;
      end else if (gnt) begin
        GrantIdx_DO <= gnt_idx;
        WrAddr_DO   <= ReqAddr_DI[gnt_idx];
        WrData_DO   <= ReqData_DI[gnt_idx];
        WrEn_SO     <= {1'b0, ReqAddr_DI[gnt_idx]} < DEPTH;
        AddrErr_SO  <= {1'b0, ReqAddr_DI[gnt_idx]} >= DEPTH;
        ptr         <= gnt_idx == IDX_WIDTH'(NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ram_write_scheduler.sv
// tb_ram_write_scheduler: table vectors, corner sequences and random traffic against a behavioural model
module tb_ram_write_scheduler;
  localparam int AW = 3, DD = 6, DW = 16, N = 4, IW = 2;
  localparam logic [DW-1:0] SENT = 16'hA5A5;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, mem_clr = 1'b1;
  logic [N-1:0] valid = '0, ready;
  logic [N-1:0][AW-1:0] addr = '0;
  logic [N-1:0][DW-1:0] data = '0;
  logic wr_en, busy, aerr;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [IW-1:0] gidx;
  int total = 0, bad = 0;
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] emem [2**AW];
  int m_clr, m_ptr, m_gnt;
  logic e_en, e_err;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  logic [IW-1:0] e_gidx;
  typedef struct {bit fl; logic [N-1:0] v; logic [N-1:0] r; bit bad1;} vec_t;
  vec_t tbl [18];

  ram_write_scheduler #(.ADDR_WIDTH(AW), .DATA_DEPTH(DD), .DATA_WIDTH(DW), .NUM_REQ(N)) dut (
    .Clk_CI(clk), .Rst_RBI(rst_n), .Flush_SI(flush), .ReqValid_SI(valid), .ReqReady_SO(ready),
    .ReqAddr_DI(addr), .ReqData_DI(data), .WrEn_SO(wr_en), .WrAddr_DO(wr_addr), .WrData_DO(wr_data),
    .GrantIdx_DO(gidx), .Busy_SO(busy), .AddrErr_SO(aerr));

  always #5 clk = ~clk;

  // the RAM the scheduler drives
  always @(posedge clk) begin
    if (mem_clr) for (int k = 0; k < 2**AW; k++) mem[k] <= SENT;
    else if (wr_en) mem[wr_addr] <= wr_data;
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic int exp_gnt();
    if (m_clr > 0 || flush) return -1;
    for (int k = 0; k < N; k++) if (valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_clr = DD; m_ptr = 0; m_gnt = -1;
    e_en = 1'b0; e_err = 1'b0; e_addr = '0; e_data = '0; e_gidx = '0;
  endtask

  // called at the negedge: compare this cycle, advance the model, return at posedge+1
  task automatic model_tick();
    int g;
    logic [N-1:0] er;
    g = exp_gnt();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("ready", ready, er);
    chk("busy", busy, m_clr > 0);
    chk("wr_en", wr_en, e_en);
    chk("wr_addr", wr_addr, e_addr);
    chk("wr_data", wr_data, e_data);
    chk("grant_idx", gidx, e_gidx);
    chk("addr_err", aerr, e_err);
    e_en = 1'b0; e_err = 1'b0;
    if (m_clr > 0) begin
      e_en = 1'b1; e_addr = AW'(DD - m_clr); e_data = '0; emem[e_addr] = '0; m_clr--;
    end else if (flush) m_clr = DD;
    else if (g >= 0) begin
      e_gidx = IW'(g); e_addr = addr[g]; e_data = data[g];
      if (int'(addr[g]) < DD) begin e_en = 1'b1; emem[addr[g]] = data[g]; end
      else e_err = 1'b1;
      m_ptr = (g + 1) % N;
    end
    m_gnt = g;
    @(posedge clk); #1;
  endtask

  task automatic step();
    @(negedge clk);
    model_tick();
  endtask

  task automatic idle(input int n);
    flush = 1'b0; valid = '0;
    repeat (n) step();
  endtask

  // asynchronous reset: outputs must reach reset values without a clock edge
  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; valid = '1;
    #3;
    chk("rst_ready", ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_grant_idx", gidx, 0);
    chk("rst_busy", busy, 1);
    chk("rst_addr_err", aerr, 0);
    @(posedge clk); #1;
    valid = '0; rst_n = 1'b1;
    model_reset();
  endtask

  task automatic chk_mem(input string n);
    for (int k = 0; k < 2**AW; k++) chk(n, mem[k], emem[k]);
  endtask

  initial begin
    tbl[0]  = '{0, 4'b1111, 4'b0001, 0};
    tbl[1]  = '{0, 4'b1111, 4'b0010, 1};
    tbl[2]  = '{0, 4'b1111, 4'b0100, 0};
    tbl[3]  = '{0, 4'b1111, 4'b1000, 0};
    tbl[4]  = '{0, 4'b1111, 4'b0001, 0};
    tbl[5]  = '{0, 4'b0000, 4'b0000, 0};
    tbl[6]  = '{0, 4'b0001, 4'b0001, 0};
    tbl[7]  = '{0, 4'b0100, 4'b0100, 0};
    tbl[8]  = '{0, 4'b0100, 4'b0100, 0};
    tbl[9]  = '{0, 4'b1001, 4'b1000, 0};
    tbl[10] = '{1, 4'b0001, 4'b0000, 0};
    for (int i = 11; i < 17; i++) tbl[i] = '{0, 4'b0001, 4'b0000, 0};
    tbl[17] = '{0, 4'b0001, 4'b0001, 0};
    for (int k = 0; k < 2**AW; k++) emem[k] = SENT;
    @(posedge clk); #1;
    mem_clr = 1'b0;
    do_reset();
    idle(DD + 1);
    chk_mem("mem_after_init");
    for (int i = 0; i < 18; i++) begin
      flush = tbl[i].fl; valid = tbl[i].v;
      for (int j = 0; j < N; j++) begin
        addr[j] = AW'($urandom_range(0, DD - 1));
        data[j] = DW'($urandom);
      end
      if (tbl[i].bad1) addr[1] = 3'd7;
      @(negedge clk);
      chk($sformatf("tbl_ready[%0d]", i), ready, tbl[i].r);
      model_tick();
    end
    idle(2);
    chk_mem("mem_after_table");
    do_reset();
    idle(5);
    do_reset();
    idle(DD + 2);
    chk_mem("mem_after_midclear_reset");
    for (int c = 0; c < 400; c++) begin
      for (int j = 0; j < N; j++)
        if (!(valid[j] && j != m_gnt && $urandom_range(0, 5) != 0)) begin
          valid[j] = 1'($urandom_range(0, 1));
          addr[j] = AW'($urandom_range(0, 7));
          data[j] = DW'($urandom);
        end
      flush = $urandom_range(0, 39) == 0;
      step();
    end
    idle(DD + 3);
    chk_mem("mem_after_random");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ram_write_scheduler.md
# ram_write_scheduler

Write-port controller for the team's asynchronous multi-read-port RAMs (one write port, several combinational read ports). It clears the whole array after reset or on demand, then shares the single write port between NUM_REQ requesters with a round-robin valid/ready handshake. All RAM-side outputs are registered, so they connect directly to the RAM's write-enable, write-address and write-data inputs.

## Interface
- ADDR_WIDTH, 10, RAM address width.
- DATA_DEPTH, 1024, number of RAM entries; must satisfy DATA_DEPTH <= 2**ADDR_WIDTH.
- DATA_WIDTH, 32, RAM word width.
- NUM_REQ, 4, number of write requesters, >= 2.
- Clk_CI  in  1  clock; the only clock.
- Rst_RBI  in  1  reset, asynchronous, active-low.
- Flush_SI  in  1  level request to clear the RAM to zero.
- ReqValid_SI  in  NUM_REQ  per-requester write request.
- ReqReady_SO  out  NUM_REQ  per-requester accept, at most one bit set.
- ReqAddr_DI  in  NUM_REQ x ADDR_WIDTH  per-requester write address.
- ReqData_DI  in  NUM_REQ x DATA_WIDTH  per-requester write data.
- WrEn_SO  out  1  RAM write enable, registered.
- WrAddr_DO  out  ADDR_WIDTH  RAM write address, registered.
- WrData_DO  out  DATA_WIDTH  RAM write data, registered.
- GrantIdx_DO  out  clog2(NUM_REQ)  requester whose write is on the port this cycle, registered.
- Busy_SO  out  1  1 while clearing.
- AddrErr_SO  out  1  one-cycle pulse: a dropped out-of-range write.

## Operation
- States: CLEAR and RUN. Reset enters CLEAR with the clear counter at 0.
- Reset values: WrEn_SO=0, WrAddr_DO=0, WrData_DO=0, GrantIdx_DO=0, AddrErr_SO=0, Busy_SO=1, round-robin pointer=0, ReqReady_SO=0.
- CLEAR:
  - Each cycle, register a write of zero to the counter address, then increment the counter.
  - When the counter reaches DATA_DEPTH-1, that write is issued and the state moves to RUN at the same edge.
  - The counter never wraps through the unused addresses DATA_DEPTH..2**ADDR_WIDTH-1.
  - ReqReady_SO is all-zero. Flush_SI is ignored.
- RUN:
  - Busy_SO=0.
  - If Flush_SI=1: no grant that cycle (flush wins), the counter loads 0, and the state moves to CLEAR next edge.
  - Otherwise ReqReady_SO is one-hot on the first i with ReqValid_SI[i]=1, searching cyclically from the pointer. If no requester is valid, ReqReady_SO is all-zero.
  - ReqReady_SO is combinational from ReqValid_SI, the pointer, the state and Flush_SI.
  - On a grant to requester g, the pointer becomes (g+1) mod NUM_REQ. With no grant, the pointer is unchanged.
- Granted write, output register update at the next edge:
  - GrantIdx_DO=g.
  - WrAddr_DO and WrData_DO take the granted address and data.
  - If the address is < DATA_DEPTH: WrEn_SO=1.
  - If the address is >= DATA_DEPTH: WrEn_SO=0 and AddrErr_SO=1 for one cycle. The requester's handshake still completes.
- In cycles with no write, WrEn_SO=0. WrAddr_DO and WrData_DO hold their last values.
- Requesters must hold valid, address and data stable until ready. Dropping valid before ready is allowed; nothing is written.
- Reset mid-operation (CLEAR or RUN) aborts everything. Any registered write not yet presented is lost. CLEAR restarts from address 0.

## Timing
- One write per cycle at most. Handshake in cycle N gives WrEn_SO=1 in cycle N+1. The RAM writes at the edge ending cycle N+1, and the data is readable on the RAM's asynchronous ports from cycle N+2.
- After reset release, clear writes to addresses 0..DATA_DEPTH-1 appear on WrEn_SO in consecutive cycles 1..DATA_DEPTH, where cycle 0 is the first cycle after release.
- Busy_SO=1 in cycles 0..DATA_DEPTH-1 and 0 from cycle DATA_DEPTH, which is also the cycle the last clear write is presented.
- The first grant is possible in cycle DATA_DEPTH, and its write appears in cycle DATA_DEPTH+1. Clear writes therefore always precede requester writes.
- Flush_SI sampled 1 in RUN cycle F: Busy_SO=1 from F+1, clear writes appear in F+2..F+1+DATA_DEPTH, and Busy_SO=0 from F+1+DATA_DEPTH.
- A continuously valid requester is granted at least once every NUM_REQ grant cycles.

## Test plan
- Reset with DATA_DEPTH=6, ADDR_WIDTH=3 -> WrEn_SO=1 with WrAddr_DO=0..5 and data 0 in cycles 1..6. Busy_SO falls at cycle 6. Address 6 and 7 are never written.
- All 4 requesters valid continuously after init -> grants in order 0,1,2,3,0. Each write appears one cycle after its handshake, and GrantIdx_DO matches.
- Only requester 2 valid, pointer at 3 -> ReqReady_SO=0100. The pointer becomes 3 again, and a following request from requester 3 wins over requester 0.
- Requester 1 writes address 7 with DATA_DEPTH=6 -> handshake completes, WrEn_SO=0, AddrErr_SO pulses for 1 cycle, and the RAM is unchanged.
- Flush_SI=1 in the same cycle requester 0 is valid -> ReqReady_SO=0, Busy_SO rises next cycle, and a full clear runs. Requester 0 is then granted in the first RUN cycle.
- Assert Rst_RBI=0 midway through CLEAR (after address 3) -> outputs go to reset values immediately, and on release the clear restarts at address 0.
